// File: rtl/alu_mdu_if.sv
// ALU / multiply-divide unit bus: operands, ALU select/result,
// multiply-divide request and HI/LO/busy status.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] S1;
    logic [WIDTH-1:0] S2;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic [2:0]       md_op;
    logic             md_start;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output S1, S2, ALUControl, md_op, md_start,
        input  ALUResult, busy, hi, lo
    );

    modport slave (
        input  S1, S2, ALUControl, md_op, md_start,
        output ALUResult, busy, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// Combinational ALU plus multi-cycle multiply/divide with HI/LO.
// Divider present only when ALU_MDU_DIV_EN is defined.
module alu_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    alu_mdu_if.slave   bus
);
    localparam int SW   = $clog2(WIDTH);
    localparam int HW   = WIDTH / 2;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [WIDTH-1:0] res;
    logic [SW-1:0]    sh;

    assign sh = bus.S1[SW-1:0];

    always_comb begin
        res = '0;
        case (bus.ALUControl)
            4'd0:    res = bus.S1 | bus.S2;
            4'd1:    res = {bus.S2[HW-1:0], {HW{1'b0}}};
            4'd2:    res = bus.S1 + bus.S2;
            4'd3:    res = bus.S1 - bus.S2;
            4'd4:    res = bus.S1 & bus.S2;
            4'd5:    res = bus.S1 ^ bus.S2;
            4'd6:    res = ~(bus.S1 | bus.S2);
            4'd7:    res = {{(WIDTH-1){1'b0}}, $signed(bus.S1) < $signed(bus.S2)};
            4'd8:    res = {{(WIDTH-1){1'b0}}, bus.S1 < bus.S2};
            4'd9:    res = bus.S2 << sh;
            4'd10:   res = bus.S2 >> sh;
            4'd11:   res = WIDTH'($signed(bus.S2) >>> sh);
            default: res = '0;
        endcase
    end

    assign bus.ALUResult = res;

    logic             active;
    logic [CW-1:0]    cnt;
    logic             is_sgn;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic idle_req;
    logic go_mul;
    logic go_hi;
    logic go_lo;

    assign idle_req = bus.md_start & ~active;
    assign go_mul   = idle_req & (bus.md_op[2:1] == 2'b00);
    assign go_hi    = idle_req & (bus.md_op == 3'd4);
    assign go_lo    = idle_req & (bus.md_op == 3'd5);

    // Sign-extending both operands makes one 2W-bit multiply serve mult and multu.
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;

    assign ext_a = {{WIDTH{is_sgn & opa[WIDTH-1]}}, opa};
    assign ext_b = {{WIDTH{is_sgn & opb[WIDTH-1]}}, opb};
    assign prod  = ext_a * ext_b;

`ifdef ALU_MDU_DIV_EN
    logic             go_div;
    logic             is_div;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] ua;
    logic [WIDTH-1:0] ub;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    assign go_div = idle_req & (bus.md_op[2:1] == 2'b01);

    // Magnitude divide; most-negative / -1 falls out as quotient MIN, remainder 0.
    assign neg_a = is_sgn & opa[WIDTH-1];
    assign neg_b = is_sgn & opb[WIDTH-1];
    assign ua    = neg_a ? -opa : opa;
    assign ub    = neg_b ? -opb : opb;
    assign uq    = (ub == '0) ? '0 : ua / ub;
    assign ur    = (ub == '0) ? '0 : ua % ub;
    assign quo   = (neg_a ^ neg_b) ? -uq : uq;
    assign rem   = neg_a ? -ur : ur;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            cnt    <= '0;
            is_sgn <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef ALU_MDU_DIV_EN
            is_div <= 1'b0;
`endif
        end else begin
            unique case (1'b1)
                active: begin
                    if (cnt == '0) begin
                        active <= 1'b0;
`ifdef ALU_MDU_DIV_EN
                        if (is_div) begin
                            if (opb != '0) begin
                                hi_q <= rem;
                                lo_q <= quo;
                            end
                        end else begin
                            hi_q <= prod[2*WIDTH-1:WIDTH];
                            lo_q <= prod[WIDTH-1:0];
                        end
`else
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                go_mul: begin
                    active <= 1'b1;
                    cnt    <= CW'(MULT_CYCLES - 1);
                    is_sgn <= ~bus.md_op[0];
                    opa    <= bus.S1;
                    opb    <= bus.S2;
`ifdef ALU_MDU_DIV_EN
                    is_div <= 1'b0;
`endif
                end
`ifdef ALU_MDU_DIV_EN
                go_div: begin
                    active <= 1'b1;
                    cnt    <= CW'(DIV_CYCLES - 1);
                    is_sgn <= ~bus.md_op[0];
                    opa    <= bus.S1;
                    opb    <= bus.S2;
                    is_div <= 1'b1;
                end
`endif
                go_hi:   hi_q <= bus.S1;
                go_lo:   lo_q <= bus.S1;
                default: ;
            endcase
        end
    end

    assign bus.busy = active;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (even, >=8).
REQ-002 Parameter MULT_CYCLES, default 5, busy cycles for multiply (>=1).
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for divide (>=1).
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port S1  input  WIDTH  operand A / rs value.
REQ-007 Port S2  input  WIDTH  operand B / rt value.
REQ-008 Port ALUControl  input  4  combinational ALU op select.
REQ-009 Port ALUResult  output  WIDTH  combinational ALU result.
REQ-010 Port md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved.
REQ-011 Port md_start  input  1  one-cycle request qualifying md_op.
REQ-012 Port busy  output  1  multi-cycle operation in flight.
REQ-013 Port hi  output  WIDTH  HI register.
REQ-014 Port lo  output  WIDTH  LO register.

Function
REQ-015 ALUControl decode: 0 OR, 1 S2 low half shifted to upper half (low half zero), 2 ADD, 3 SUB, 4 AND, 5 XOR, 6 NOR, 7 SLT signed, 8 SLTU, 9 SLL S2 by S1[log2(WIDTH)-1:0], 10 SRL, 11 SRA; 12-15 result zero.
REQ-016 ADD/SUB wrap modulo 2^WIDTH; no overflow flag; SLT/SLTU result is 0 or 1 zero-extended.
REQ-017 ALUResult independent of busy, md_start and clock.
REQ-018 md_start with md_op 0-3 while busy low: S1/S2 and op sampled at that edge; busy high the next cycle.
REQ-019 busy stays high exactly MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) cycles, then falls; hi/lo take the result on the same edge busy falls.
REQ-020 mult/multu: {hi,lo} = full 2*WIDTH product, signed resp. unsigned.
REQ-021 div/divu: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-022 Divide by zero: busy cycles run normally; hi and lo unchanged at completion.
REQ-023 Signed div of most-negative by -1: lo = most-negative value, hi = 0.
REQ-024 mthi/mtlo with busy low: hi (resp. lo) = S1 at that edge; busy stays low; other register unchanged.
REQ-025 md_start while busy high (any op): ignored, no state change, in-flight op unaffected.
REQ-026 md_op 6-7 with md_start: no effect.
REQ-027 md_start coincident with busy falling edge cycle (last busy cycle): ignored; new op accepted only when busy sampled low.
REQ-028 hi/lo hold value between updates; outputs are register outputs, no combinational path from inputs.

Reset
REQ-029 reset low asynchronously forces busy=0, hi=0, lo=0, cycle counter cleared, in-flight op discarded.
REQ-030 Release of reset is synchronised to clk; first md_start honoured on first edge after release.
REQ-031 ALUResult unaffected by reset.

Configuration
REQ-032 Macro ALU_MDU_DIV_EN defined: div/divu implemented per REQ-019..023.
REQ-033 Macro ALU_MDU_DIV_EN undefined: div/divu treated as md_op 6-7 (no busy, hi/lo unchanged); no divider logic synthesised; mult, mthi, mtlo, ALU unchanged.

Verification
REQ-034 WIDTH=32: ALUControl=1, S2=0x00001234 -> ALUResult=0x12340000; ALUControl=7, S1=0xFFFFFFFF, S2=1 -> 1; ALUControl=8 same operands -> 0.
REQ-035 mult start, S1=0xFFFFFFFE, S2=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-036 div S1=0xFFFFFFF9 (-7), S2=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; div S2=0 -> hi/lo unchanged.
REQ-037 mult in flight, mtlo start with S1=0xAAAA5555 on busy cycle 2 -> ignored; final lo equals product low word.
REQ-038 div in flight, reset low on busy cycle 4 -> busy, hi, lo = 0 immediately; no late write after release.
REQ-039 Build without ALU_MDU_DIV_EN: div start -> busy never asserts, hi/lo unchanged; mthi S1=0x5 -> hi=0x5 next cycle.
